req_initiator: RTL and testbench

Request-side initiator for the single-cycle req/gnt handshake used by the simple grant pipeline DUTs. On a start pulse it issues a burst of requests, holding each `req` high until `gnt` is sampled. It measures per-request grant latency, enforces a grant timeout, and reports completion and error status. It sits in front of a granting block or inside a test harness as the stimulus end of the protocol.

---
 rtl/req_init_pkg.sv | 17 +
 rtl/req_initiator_if.sv | 27 ++
 rtl/req_initiator_wait_timer.sv | 42 ++++
 rtl/req_initiator.sv | 165 ++++++++++++++++
 tb/tb_req_initiator.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/req_init_pkg.sv
// Shared types and constants for the req/gnt request initiator.
// Holds the FSM state encoding, counter width and a saturating increment helper.
package req_init_pkg;

    localparam int REQ_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } req_state_e;

    function automatic logic [REQ_CNT_W-1:0] sat_inc(input logic [REQ_CNT_W-1:0] v);
        return (v == {REQ_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/req_initiator_if.sv
// Bundle of the start/status and req/gnt signals between the initiator and its peer.
// req is raised by the initiator and held high until gnt is sampled high on a posedge;
// a single gnt cycle completes one request, and gnt outside a request is spurious.
interface req_initiator_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             gnt;
    logic             req;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             spurious;
    logic [7:0]       last_lat;
    logic [LEN_W-1:0] grant_cnt;

    modport master (
        input  start, len, gnt,
        output req, busy, done, timeout, spurious, last_lat, grant_cnt
    );

    modport slave (
        output start, len, gnt,
        input  req, busy, done, timeout, spurious, last_lat, grant_cnt
    );
endinterface

// File: rtl/req_initiator_wait_timer.sv
// Loadable 8-bit up-counter with clear and terminal-count compare.
// Clear wins over load, load wins over increment.
module req_wait_timer
    import req_init_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [REQ_CNT_W-1:0] load_val,
    input  logic                 inc,
    input  logic [REQ_CNT_W-1:0] term,
    output logic [REQ_CNT_W-1:0] cnt,
    output logic                 tc
);

    logic [REQ_CNT_W-1:0] cnt_q;
    logic [REQ_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == term);

endmodule

// File: rtl/req_initiator.sv
// Request-side initiator: issues a burst of req/gnt handshakes on start,
// measures grant latency, enforces a grant timeout and reports burst status.
module req_initiator
    import req_init_pkg::req_state_e;
    import req_init_pkg::IDLE;
    import req_init_pkg::REQ;
    import req_init_pkg::REQ_CNT_W;
    import req_init_pkg::sat_inc;
#(
    parameter int MAX_WAIT = 4,
    parameter int GAP      = 1,
    parameter int LEN_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    req_initiator_if.master  bus,
    output req_state_e       dbg_state
);

    // Timers fire when count equals term, i.e. on the N-th cycle of the phase.
    localparam logic [REQ_CNT_W-1:0] WAIT_TERM = REQ_CNT_W'(MAX_WAIT - 1);
    localparam logic [REQ_CNT_W-1:0] GAP_TERM  = (GAP > 0) ? REQ_CNT_W'(GAP - 1) : '0;

    req_state_e           state_q, state_d;
    logic                 req_q, req_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic                 spurious_q, spurious_d;
    logic [7:0]           last_lat_q, last_lat_d;
    logic [LEN_W-1:0]     grant_cnt_q, grant_cnt_d;
    logic [LEN_W-1:0]     remaining_q, remaining_d;

    logic                 wait_clr, wait_inc, wait_tc;
    logic                 gap_clr, gap_inc, gap_tc;
    logic [REQ_CNT_W-1:0] wait_cnt;
    logic [REQ_CNT_W-1:0] gap_cnt;

    req_wait_timer u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wait_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (wait_inc),
        .term     (WAIT_TERM),
        .cnt      (wait_cnt),
        .tc       (wait_tc)
    );

    req_wait_timer u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (gap_clr),
        .load     (1'b0),
        .load_val ('0),
        .inc      (gap_inc),
        .term     (GAP_TERM),
        .cnt      (gap_cnt),
        .tc       (gap_tc)
    );

    always_comb begin
        state_d     = state_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        spurious_d  = spurious_q;
        last_lat_d  = last_lat_q;
        grant_cnt_d = grant_cnt_q;
        remaining_d = remaining_q;
        wait_clr    = 1'b1;
        wait_inc    = 1'b0;
        gap_clr     = 1'b1;
        gap_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    timeout_d   = 1'b0;
                    spurious_d  = 1'b0;
                    grant_cnt_d = '0;
                    if (bus.len != '0) begin
                        remaining_d = bus.len;
                        state_d     = REQ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // A grant on the last allowed cycle beats the timeout.
                if (bus.gnt) begin
                    last_lat_d  = sat_inc(wait_cnt);
                    grant_cnt_d = grant_cnt_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (GAP > 0) begin
                        state_d = req_init_pkg::GAP;
                    end
                end else if (wait_tc) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_clr = 1'b0;
                    wait_inc = 1'b1;
                end
            end
            req_init_pkg::GAP: begin
                if (gap_tc) begin
                    state_d = REQ;
                end else begin
                    gap_clr = 1'b0;
                    gap_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.gnt && (state_q != REQ)) begin
            spurious_d = 1'b1;
        end

        req_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            spurious_q  <= 1'b0;
            last_lat_q  <= '0;
            grant_cnt_q <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            spurious_q  <= spurious_d;
            last_lat_q  <= last_lat_d;
            grant_cnt_q <= grant_cnt_d;
            remaining_q <= remaining_d;
        end
    end

    assign bus.req       = req_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.timeout   = timeout_q;
    assign bus.spurious  = spurious_q;
    assign bus.last_lat  = last_lat_q;
    assign bus.grant_cnt = grant_cnt_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_req_initiator.sv
// Directed bench for req_initiator: one instance with GAP=1 and one with GAP=0,
// both MAX_WAIT=4, walking through grant, timeout, len=0, spurious and reset cases.
module tb_req_initiator;
    import req_init_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    req_initiator_if #(.LEN_W(8)) bus_a ();
    req_initiator_if #(.LEN_W(8)) bus_b ();
    req_state_e dbg_a;
    req_state_e dbg_b;

    // Responder for instance A: either a 2-cycle fixed-delay model or a direct drive.
    logic resp_en;
    logic gnt_drv;
    logic resp_r1;

    req_initiator #(.MAX_WAIT(4), .GAP(1), .LEN_W(8)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_a.master),
        .dbg_state (dbg_a)
    );

    req_initiator #(.MAX_WAIT(4), .GAP(0), .LEN_W(8)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_b.master),
        .dbg_state (dbg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) resp_r1 <= 1'b0;
        else        resp_r1 <= bus_a.req;
    end

    assign bus_a.gnt = resp_en ? (resp_r1 & bus_a.req) : gnt_drv;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int  rises;
    int  req_cycles;
    int  done_cnt;
    int  done_idx;
    int  req_after;
    logic prev_req;
    logic [7:0] prev_gc;

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        resp_en       = 1'b0;
        gnt_drv       = 1'b0;
        bus_a.start   = 1'b0;
        bus_a.len     = '0;
        bus_b.start   = 1'b0;
        bus_b.len     = '0;
        bus_b.gnt     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req",       32'(bus_a.req),       0);
        check("rst_busy",      32'(bus_a.busy),      0);
        check("rst_done",      32'(bus_a.done),      0);
        check("rst_timeout",   32'(bus_a.timeout),   0);
        check("rst_spurious",  32'(bus_a.spurious),  0);
        check("rst_last_lat",  32'(bus_a.last_lat),  0);
        check("rst_grant_cnt", 32'(bus_a.grant_cnt), 0);
        check("rst_state",     32'(dbg_a),           32'(IDLE));
        rst_n = 1'b1;
        tick();

        // Burst of 3 against a 2-cycle responder
        resp_en     = 1'b1;
        bus_a.start = 1'b1;
        bus_a.len   = 8'd3;
        tick();
        bus_a.start = 1'b0;
        check("t1_req_after_start",  32'(bus_a.req),  1);
        check("t1_busy_after_start", 32'(bus_a.busy), 1);
        rises = 1; req_cycles = 1; done_cnt = 0; done_idx = 0;
        prev_req = bus_a.req; prev_gc = bus_a.grant_cnt;
        for (int c = 1; c <= 20 && done_cnt == 0; c++) begin
            tick();
            if (bus_a.req && !prev_req) rises++;
            if (bus_a.req) req_cycles++;
            if (bus_a.grant_cnt != prev_gc) check("t1_last_lat", 32'(bus_a.last_lat), 2);
            if (bus_a.done) begin
                done_cnt++;
                done_idx = c;
            end
            prev_req = bus_a.req;
            prev_gc  = bus_a.grant_cnt;
        end
        check("t1_req_rises",  32'(rises),           3);
        check("t1_req_cycles", 32'(req_cycles),      6);
        check("t1_done_edge",  32'(done_idx),        8);
        check("t1_grant_cnt",  32'(bus_a.grant_cnt), 3);
        check("t1_timeout",    32'(bus_a.timeout),   0);
        check("t1_spurious",   32'(bus_a.spurious),  0);
        check("t1_busy_end",   32'(bus_a.busy),      0);
        check("t1_req_end",    32'(bus_a.req),       0);
        tick();
        check("t1_done_single", 32'(bus_a.done), 0);
        resp_en = 1'b0;
        gnt_drv = 1'b0;
        tick();

        // No grant: timeout after MAX_WAIT cycles aborts a burst of 5
        bus_a.start = 1'b1;
        bus_a.len   = 8'd5;
        tick();
        bus_a.start = 1'b0;
        req_cycles = bus_a.req ? 1 : 0;
        done_idx = 0;
        for (int c = 1; c <= 20 && done_idx == 0; c++) begin
            tick();
            if (bus_a.req) req_cycles++;
            if (bus_a.done) done_idx = c;
        end
        check("t2_req_cycles", 32'(req_cycles),      4);
        check("t2_done_edge",  32'(done_idx),        4);
        check("t2_timeout",    32'(bus_a.timeout),   1);
        check("t2_grant_cnt",  32'(bus_a.grant_cnt), 0);
        req_after = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus_a.req) req_after++;
        end
        check("t2_req_stays_low", 32'(req_after),     0);
        check("t2_timeout_held",  32'(bus_a.timeout), 1);

        // Grant on the MAX_WAIT-th edge counts as a grant
        bus_a.start = 1'b1;
        bus_a.len   = 8'd1;
        tick();
        bus_a.start = 1'b0;
        check("t3_timeout_cleared", 32'(bus_a.timeout), 0);
        check("t3_req_up",          32'(bus_a.req),     1);
        tick();
        tick();
        tick();
        gnt_drv = 1'b1;
        tick();
        gnt_drv = 1'b0;
        check("t3_last_lat",  32'(bus_a.last_lat),  4);
        check("t3_timeout",   32'(bus_a.timeout),   0);
        check("t3_grant_cnt", 32'(bus_a.grant_cnt), 1);
        check("t3_done",      32'(bus_a.done),      1);
        check("t3_req_low",   32'(bus_a.req),       0);
        tick();

        // GAP=0 with gnt held high; a mid-burst start is ignored
        bus_b.start = 1'b1;
        bus_b.len   = 8'd4;
        tick();
        bus_b.start = 1'b0;
        bus_b.gnt   = 1'b1;
        req_cycles = bus_b.req ? 1 : 0;
        tick();
        if (bus_b.req) req_cycles++;
        bus_b.start = 1'b1;
        bus_b.len   = 8'd9;
        tick();
        if (bus_b.req) req_cycles++;
        bus_b.start = 1'b0;
        tick();
        if (bus_b.req) req_cycles++;
        tick();
        if (bus_b.req) req_cycles++;
        check("t4_req_cycles", 32'(req_cycles),      4);
        check("t4_done",       32'(bus_b.done),      1);
        check("t4_grant_cnt",  32'(bus_b.grant_cnt), 4);
        check("t4_last_lat",   32'(bus_b.last_lat),  1);
        tick();
        check("t4_spurious_idle",  32'(bus_b.spurious),  1);
        check("t4_req_after",      32'(bus_b.req),       0);
        check("t4_busy_after",     32'(bus_b.busy),      0);
        check("t4_grant_cnt_hold", 32'(bus_b.grant_cnt), 4);
        bus_b.gnt = 1'b0;

        // len=0 start, then a spurious grant while idle
        bus_a.start = 1'b1;
        bus_a.len   = 8'd0;
        tick();
        bus_a.start = 1'b0;
        check("t5_done",      32'(bus_a.done),      1);
        check("t5_req",       32'(bus_a.req),       0);
        check("t5_busy",      32'(bus_a.busy),      0);
        check("t5_grant_cnt", 32'(bus_a.grant_cnt), 0);
        tick();
        check("t5_done_single", 32'(bus_a.done), 0);
        check("t5_req_low",     32'(bus_a.req),  0);
        gnt_drv = 1'b1;
        tick();
        gnt_drv = 1'b0;
        check("t5_spurious",      32'(bus_a.spurious),  1);
        check("t5_grant_ignored", 32'(bus_a.grant_cnt), 0);
        check("t5_last_lat_hold", 32'(bus_a.last_lat),  4);
        bus_a.start = 1'b1;
        bus_a.len   = 8'd1;
        tick();
        bus_a.start = 1'b0;
        check("t5_spurious_cleared", 32'(bus_a.spurious), 0);
        gnt_drv = 1'b1;
        tick();
        gnt_drv = 1'b0;
        check("t5_done2",     32'(bus_a.done),     1);
        check("t5_last_lat2", 32'(bus_a.last_lat), 1);
        tick();

        // Asynchronous reset during the second request of a 3-request burst
        bus_a.start = 1'b1;
        bus_a.len   = 8'd3;
        tick();
        bus_a.start = 1'b0;
        gnt_drv = 1'b1;
        tick();
        gnt_drv = 1'b0;
        check("t6_grant1",   32'(bus_a.grant_cnt), 1);
        tick();
        check("t6_req_pre",  32'(bus_a.req),       1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_req_rst",       32'(bus_a.req),       0);
        check("t6_busy_rst",      32'(bus_a.busy),      0);
        check("t6_grant_cnt_rst", 32'(bus_a.grant_cnt), 0);
        check("t6_last_lat_rst",  32'(bus_a.last_lat),  0);
        check("t6_state_rst",     32'(dbg_a),           32'(IDLE));
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus_a.done) done_cnt++;
        end
        check("t6_no_done", 32'(done_cnt), 0);
        rst_n = 1'b1;
        tick();
        bus_a.start = 1'b1;
        bus_a.len   = 8'd2;
        tick();
        bus_a.start = 1'b0;
        check("t6_req_restart", 32'(bus_a.req), 1);
        gnt_drv = 1'b1;
        tick();
        gnt_drv = 1'b0;
        tick();
        gnt_drv = 1'b1;
        tick();
        gnt_drv = 1'b0;
        check("t6_done",      32'(bus_a.done),      1);
        check("t6_grant_cnt", 32'(bus_a.grant_cnt), 2);
        check("t6_spurious",  32'(bus_a.spurious),  0);
        check("t6_timeout",   32'(bus_a.timeout),   0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
